// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential divider: FSM state encoding and a
//   constant-evaluable ceil(log2) used to size the iteration counter.
// ----------------------------------------------------------------------------
package div_pkg;

    // Fixed encoding so state values stay stable across builds and in debug.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : div_pkg

// File: rtl/div_sub_stage.sv
// ----------------------------------------------------------------------------
// div_sub_stage
//   Combinational (WIDTH+1)-bit trial subtract for one restoring-division
//   step, formed as a + ~b + 1. The carry out of the top bit is the
//   no-borrow flag (a >= b).
// Ports
//   a_i          in   WIDTH+1  minuend (shifted partial remainder)
//   b_i          in   WIDTH+1  subtrahend (zero-extended divisor)
//   diff_o       out  WIDTH+1  a_i - b_i, modulo 2^(WIDTH+1)
//   no_borrow_o  out  1        1 when a_i >= b_i
// ----------------------------------------------------------------------------
module div_sub_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    output logic [WIDTH:0] diff_o,
    output logic           no_borrow_o
);

    logic [WIDTH+1:0] sum;

    assign sum         = {1'b0, a_i} + {1'b0, ~b_i} + {{(WIDTH + 1){1'b0}}, 1'b1};
    assign diff_o      = sum[WIDTH:0];
    assign no_borrow_o = sum[WIDTH+1];

endmodule : div_sub_stage

// File: rtl/div8_seq.sv
// ----------------------------------------------------------------------------
// div8_seq
//   Sequential restoring divider, one quotient bit per clock. Started by the
//   control unit for DIV/MOD; results are valid on the one-cycle done pulse
//   and are held until the next divide completes.
//
//   Build option: define DIV_SIGNED_EN for two's complement operands
//   (quotient truncates toward zero, remainder takes the dividend's sign).
//   Without it only unsigned division is built. Latency is the same in both.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      request, accepted only when idle
//   dividend     in   WIDTH  numerator, sampled on the accepting edge
//   divisor      in   WIDTH  denominator, sampled on the accepting edge
//   busy         out  1      divide in progress
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result
//   remainder    out  WIDTH  result
//   div_by_zero  out  1      last divide had divisor == 0
//
// Timing (start accepted at edge 0): normal divide runs WIDTH steps on edges
// 1..WIDTH, results are published on edge WIDTH+1 so done is high in the
// cycle after it. Divide-by-zero skips CALC and done follows edge 1.
// ----------------------------------------------------------------------------
module div8_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor.
    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   diff_d;
    logic             no_borrow_d;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] q_d;

    // Operand magnitudes at load and the finished (possibly re-signed) result.
    logic [WIDTH-1:0] dvd_abs_d;
    logic [WIDTH-1:0] dvs_abs_d;
    logic [WIDTH-1:0] quot_fin_d;
    logic [WIDTH-1:0] rem_fin_d;

    // After a no-borrow step the remainder is below the divisor, so the top
    // bit of rem_q is always zero; it exists only to hold the shifted value.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    assign shift_d = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_sub_stage #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i         (shift_d),
        .b_i         ({1'b0, dvs_q}),
        .diff_o      (diff_d),
        .no_borrow_o (no_borrow_d)
    );

    assign rem_d = no_borrow_d ? diff_d : shift_d;
    assign q_d   = {q_q[WIDTH-2:0], no_borrow_d};

`ifdef DIV_SIGNED_EN
    logic neg_quot_q;
    logic neg_rem_q;

    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so MIN / -1 falls out as quotient MIN.
    assign dvd_abs_d  = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign dvs_abs_d  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign quot_fin_d = neg_quot_q ? (~q_q + 1'b1) : q_q;
    assign rem_fin_d  = neg_rem_q  ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
`else
    assign dvd_abs_d  = dividend;
    assign dvs_abs_d  = divisor;
    assign quot_fin_d = q_q;
    assign rem_fin_d  = rem_q[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        if (divisor == '0) begin
                            // Pre-load the fixed div-by-zero answer so DONE
                            // publishes it through the normal path.
                            q_q     <= '1;
                            rem_q   <= {1'b0, dividend};
                            dvs_q   <= '0;
                            dbz_q   <= 1'b1;
                            state_q <= S_DONE;
`ifdef DIV_SIGNED_EN
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
`endif
                        end else begin
                            q_q     <= dvd_abs_d;
                            rem_q   <= '0;
                            dvs_q   <= dvs_abs_d;
                            dbz_q   <= 1'b0;
                            state_q <= S_CALC;
`ifdef DIV_SIGNED_EN
                            neg_quot_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_rem_q  <= dividend[WIDTH-1];
`endif
                        end
                    end
                end

                S_CALC: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    quotient_q  <= quot_fin_d;
                    remainder_q <= rem_fin_d;
                    state_q     <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : div8_seq

// File: tb/tb_div8_seq.sv
module tb_div8_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total;
    int bad;
    int done_cnt;

    div8_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands' numeric values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
        if (b == 0) begin
            q = {W{1'b1}};
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int sa;
            int sb;
            int iq;
            int ir;
            sa = $signed(a);
            sb = $signed(b);
            iq = sa / sb;
            ir = sa % sb;
            q  = iq[W-1:0];
            r  = ir[W-1:0];
`else
            q = a / b;
            r = a % b;
`endif
            z = 1'b0;
        end
    endtask

    // Launch one divide at the next negedge, scramble operands after the
    // accepting edge, then wait (bounded) for done and check everything.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           lat;
        int           c0;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        c0  = done_cnt;
        lat = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || lat > 30) break;
            if (lat == 0) check({tag, " busy"}, 32'(busy), 32'd1);
            lat++;
        end
        check({tag, " latency"}, lat, (b == 0) ? 32'd1 : 32'(W + 1));
        check({tag, " quot"}, 32'(quotient), 32'(eq));
        check({tag, " rem"}, 32'(remainder), 32'(er));
        check({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
        @(negedge clk);
        check({tag, " pulse"}, done_cnt - c0, 32'd1);
    endtask

    initial begin
        int lat;
        int c0;
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst quot", 32'(quotient), 32'd0);
        check("rst rem", 32'(remainder), 32'd0);
        check("rst dbz", 32'(div_by_zero), 32'd0);

        // Directed cases with literal expectations (same in both modes).
        run_div("100/7", 8'd100, 8'd7);
        check("100/7 lit q", 32'(quotient), 32'd14);
        check("100/7 lit r", 32'(remainder), 32'd2);
        run_div("255/1", 8'd255, 8'd1);
        check("255/1 lit q", 32'(quotient), 32'hFF);
        check("255/1 lit r", 32'(remainder), 32'd0);
        run_div("5/9", 8'd5, 8'd9);
        check("5/9 lit q", 32'(quotient), 32'd0);
        check("5/9 lit r", 32'(remainder), 32'd5);
        run_div("255/255", 8'd255, 8'd255);
        check("255/255 lit q", 32'(quotient), 32'd1);
        run_div("200/0", 8'd200, 8'd0);
        check("200/0 lit q", 32'(quotient), 32'hFF);
        check("200/0 lit r", 32'(remainder), 32'd200);
        check("200/0 lit z", 32'(div_by_zero), 32'd1);
        run_div("after dbz", 8'd13, 8'd4);
        check("after dbz z", 32'(div_by_zero), 32'd0);

`ifdef DIV_SIGNED_EN
        run_div("-100/7", 8'h9C, 8'd7);
        check("-100/7 lit q", 32'(quotient), 32'hF2);
        check("-100/7 lit r", 32'(remainder), 32'hFE);
        run_div("100/-7", 8'd100, 8'hF9);
        check("100/-7 lit q", 32'(quotient), 32'hF2);
        check("100/-7 lit r", 32'(remainder), 32'd2);
        run_div("min/-1", 8'h80, 8'hFF);
        check("min/-1 lit q", 32'(quotient), 32'h80);
        check("min/-1 lit r", 32'(remainder), 32'd0);
        check("min/-1 lit z", 32'(div_by_zero), 32'd0);
`endif

        // start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        c0  = done_cnt;
        lat = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 || lat > 30) break;
            if (lat == 3) begin
                start = 1'b1; dividend = 8'd50; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
            lat++;
        end
        start = 1'b0;
        check("busy-ign latency", lat, 32'(W + 1));
        check("busy-ign q", 32'(quotient), 32'd14);
        check("busy-ign r", 32'(remainder), 32'd2);
        repeat (15) @(negedge clk);
        check("busy-ign pulses", done_cnt - c0, 32'd1);

        // Reset four cycles into a divide aborts it.
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        c0    = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quot", 32'(quotient), 32'd0);
        check("abort rem", 32'(remainder), 32'd0);
        check("abort dbz", 32'(div_by_zero), 32'd0);
        repeat (15) @(negedge clk);
        check("abort no done", done_cnt - c0, 32'd0);
        run_div("9/2", 8'd9, 8'd2);
        check("9/2 lit q", 32'(quotient), 32'd4);
        check("9/2 lit r", 32'(remainder), 32'd1);

        // Random operands, roughly one in eight a zero divisor.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_div($sformatf("rnd%0d %0h/%0h", i, a, b), a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div8_seq
